// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Purpose  : Multi-port integer register file with two prioritised write
//            ports, a busy scoreboard and a post-reset hardware clear.
//            Macro REGFILE_MP_BYPASS_EN adds same-cycle write-to-read forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  output logic                       ready_o,
  input  logic                       we0_i,
  input  logic [ADDR_W-1:0]          waddr0_i,
  input  logic [DATA_W-1:0]          wdata0_i,
  input  logic                       we1_i,
  input  logic [ADDR_W-1:0]          waddr1_i,
  input  logic [DATA_W-1:0]          wdata1_i,
  input  logic                       iss_we_i,
  input  logic [ADDR_W-1:0]          iss_addr_i,
  input  logic [NUM_RD-1:0]          re_i,
  input  logic [NUM_RD*ADDR_W-1:0]   raddr_i,
  output logic [NUM_RD*DATA_W-1:0]   rdata_o,
  output logic [NUM_RD-1:0]          rbusy_o,
  output logic                       wconflict_o
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic              wconflict_q, wconflict_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic run;
  logic w0_ok;
  logic w1_ok;
  logic iss_ok;

  // Writes and issues only take effect in RUN and never in a reset cycle.
  assign run    = (state_q == ST_RUN);
  assign w0_ok  = run && !rst_i && we0_i && (waddr0_i != '0);
  assign w1_ok  = run && !rst_i && we1_i && (waddr1_i != '0);
  assign iss_ok = run && !rst_i && iss_we_i && (iss_addr_i != '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    wconflict_d = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (!run) begin
      mem_d[cnt_q] = '0;
      cnt_d        = cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      if (cnt_q == {ADDR_W{1'b1}}) begin
        state_d = ST_RUN;
      end
    end else begin
      if (w0_ok) begin
        mem_d[waddr0_i]  = wdata0_i;
        busy_d[waddr0_i] = 1'b0;
      end
      if (w1_ok) begin
        mem_d[waddr1_i]  = wdata1_i;
        busy_d[waddr1_i] = 1'b0;
      end
      wconflict_d = w0_ok && w1_ok && (waddr0_i == waddr1_i);
      // A fresh issue outranks a retiring write to the same register.
      if (iss_ok) begin
        busy_d[iss_addr_i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_CLEAR;
      cnt_q       <= '0;
      busy_q      <= '0;
      wconflict_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      wconflict_q <= wconflict_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign ready_o     = run;
  assign wconflict_o = wconflict_q;

  generate
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] rd_addr;
      logic [DATA_W-1:0] rd_data;
      logic              rd_busy;

      assign rd_addr = raddr_i[k*ADDR_W +: ADDR_W];

      always_comb begin
        rd_data = '0;
        rd_busy = 1'b0;
        if (run && re_i[k] && (rd_addr != '0)) begin
          rd_data = mem_q[rd_addr];
          rd_busy = busy_q[rd_addr];
`ifdef REGFILE_MP_BYPASS_EN
          if (w1_ok && (waddr1_i == rd_addr)) begin
            rd_data = wdata1_i;
            rd_busy = iss_ok && (iss_addr_i == rd_addr);
          end else if (w0_ok && (waddr0_i == rd_addr)) begin
            rd_data = wdata0_i;
            rd_busy = iss_ok && (iss_addr_i == rd_addr);
          end
`endif
        end
      end

      assign rdata_o[k*DATA_W +: DATA_W] = rd_data;
      assign rbusy_o[k]                  = rd_busy;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp
// Purpose  : Self-checking bench for regfile_mp: directed test-plan sequences
//            plus randomized traffic checked against a behavioural model.
//            Honours REGFILE_MP_BYPASS_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 3;
  localparam int DEPTH = 32;

  logic            clk;
  logic            rst;
  logic            ready_o;
  logic            we0, we1, iss_we;
  logic [AW-1:0]   waddr0, waddr1, iss_addr;
  logic [DW-1:0]   wdata0, wdata1;
  logic [NR-1:0]   re;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata_o;
  logic [NR-1:0]   rbusy_o;
  logic            wconflict_o;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clk_i(clk), .rst_i(rst), .ready_o(ready_o),
    .we0_i(we0), .waddr0_i(waddr0), .wdata0_i(wdata0),
    .we1_i(we1), .waddr1_i(waddr1), .wdata1_i(wdata1),
    .iss_we_i(iss_we), .iss_addr_i(iss_addr),
    .re_i(re), .raddr_i(raddr), .rdata_o(rdata_o), .rbusy_o(rbusy_o),
    .wconflict_o(wconflict_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: architectural register contents and readiness.
  logic [DW-1:0] m_mem [DEPTH];
  logic          m_busy [DEPTH];
  logic          m_ready = 1'b0;
  logic          m_conf = 1'b0;
  int            m_cleared = 0;
  logic          m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_valid   = 1'b1;
      m_ready   = 1'b0;
      m_cleared = 0;
      m_conf    = 1'b0;
      for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
    end else if (!m_ready) begin
      m_mem[m_cleared] = '0;
      m_cleared++;
      if (m_cleared == DEPTH) m_ready = 1'b1;
      m_conf = 1'b0;
    end else begin
      m_conf = we0 && we1 && (waddr0 == waddr1) && (waddr0 != 0);
      if (we0 && waddr0 != 0) begin m_mem[waddr0] = wdata0; m_busy[waddr0] = 1'b0; end
      if (we1 && waddr1 != 0) begin m_mem[waddr1] = wdata1; m_busy[waddr1] = 1'b0; end
      if (iss_we && iss_addr != 0) m_busy[iss_addr] = 1'b1;
    end
  end

  task automatic exp_rd(input int k, output logic [DW-1:0] d, output logic b);
    logic [AW-1:0] a;
    a = raddr[k*AW +: AW];
    d = '0;
    b = 1'b0;
    if (m_ready && re[k] && a != 0) begin
      d = m_mem[a];
      b = m_busy[a];
`ifdef REGFILE_MP_BYPASS_EN
      if (!rst && we1 && waddr1 == a) begin
        d = wdata1; b = iss_we && (iss_addr == a);
      end else if (!rst && we0 && waddr0 == a) begin
        d = wdata0; b = iss_we && (iss_addr == a);
      end
`endif
    end
  endtask

  always @(negedge clk) begin
    logic [DW-1:0] ed;
    logic          eb;
    if (m_valid) begin
      check("ready", {31'd0, ready_o}, {31'd0, m_ready});
      check("wconflict", {31'd0, wconflict_o}, {31'd0, m_conf});
      for (int k = 0; k < NR; k++) begin
        exp_rd(k, ed, eb);
        check("rdata", rdata_o[k*DW +: DW], ed);
        check("rbusy", {31'd0, rbusy_o[k]}, {31'd0, eb});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int k, input logic [AW-1:0] a, input logic e);
    raddr[k*AW +: AW] = a;
    re[k] = e;
  endtask

  task automatic idle_writes;
    we0 = 1'b0; we1 = 1'b0; iss_we = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (ready_o !== 1'b1 && n < 100) begin
      n++;
      tick();
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, 3));
    return AW'($urandom_range(0, DEPTH-1));
  endfunction

  initial begin
    int n;
    rst = 1'b1;
    we0 = 0; we1 = 0; iss_we = 0;
    waddr0 = 0; waddr1 = 0; iss_addr = 0;
    wdata0 = 0; wdata1 = 0;
    re = 0; raddr = 0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_ready", {31'd0, ready_o}, 32'd0);
    wait_ready(n);
    check("clear_len", n, 32);

    for (int a = 0; a < DEPTH; a++) begin
      set_rd(0, AW'(a), 1'b1);
      #1;
      check("post_clear_data", rdata_o[0 +: DW], 32'd0);
      check("post_clear_busy", {31'd0, rbusy_o[0]}, 32'd0);
    end

    // two independent writes
    we0 = 1; waddr0 = 5; wdata0 = 32'h1234;
    we1 = 1; waddr1 = 7; wdata1 = 32'hBEEF;
    tick(); idle_writes();
    set_rd(0, 5, 1); set_rd(1, 7, 1);
    #1;
    check("x5", rdata_o[0 +: DW], 32'h0000_1234);
    check("x7", rdata_o[DW +: DW], 32'h0000_BEEF);
    check("no_conflict", {31'd0, wconflict_o}, 32'd0);

    // same-address conflict: port 1 wins, one-cycle pulse
    we0 = 1; waddr0 = 9; wdata0 = 32'hAAAA;
    we1 = 1; waddr1 = 9; wdata1 = 32'h5555;
    tick(); idle_writes();
    set_rd(0, 9, 1);
    #1;
    check("x9", rdata_o[0 +: DW], 32'h0000_5555);
    check("conflict_pulse", {31'd0, wconflict_o}, 32'd1);
    tick();
    check("conflict_end", {31'd0, wconflict_o}, 32'd0);
    we0 = 1; waddr0 = 0; wdata0 = 32'hFFFF;
    we1 = 1; waddr1 = 0; wdata1 = 32'hFFFF;
    tick(); idle_writes();
    set_rd(0, 0, 1);
    #1;
    check("x0", rdata_o[0 +: DW], 32'd0);
    check("x0_no_conflict", {31'd0, wconflict_o}, 32'd0);

    // scoreboard set/clear precedence
    set_rd(2, 3, 1);
    iss_we = 1; iss_addr = 3;
    tick(); idle_writes();
    #1;
    check("x3_busy", {31'd0, rbusy_o[2]}, 32'd1);
    iss_we = 1; iss_addr = 3; we0 = 1; waddr0 = 3; wdata0 = 32'h42;
    tick(); idle_writes();
    #1;
    check("x3_42", rdata_o[2*DW +: DW], 32'h42);
    check("x3_still_busy", {31'd0, rbusy_o[2]}, 32'd1);
    we1 = 1; waddr1 = 3; wdata1 = 32'h43;
    tick(); idle_writes();
    #1;
    check("x3_43", rdata_o[2*DW +: DW], 32'h43);
    check("x3_free", {31'd0, rbusy_o[2]}, 32'd0);

    // same-cycle read of a register being written
    set_rd(0, 4, 1);
    we0 = 1; waddr0 = 4; wdata0 = 32'h99;
    #1;
`ifdef REGFILE_MP_BYPASS_EN
    check("x4_same_cycle", rdata_o[0 +: DW], 32'h99);
`else
    check("x4_same_cycle", rdata_o[0 +: DW], 32'h0);
`endif
    check("x4_same_busy", {31'd0, rbusy_o[0]}, 32'd0);
    tick(); idle_writes();
    #1;
    check("x4_next", rdata_o[0 +: DW], 32'h99);

    // reset from RUN, then again mid-clear; old contents must be wiped
    rst = 1; tick(); rst = 0;
    repeat (10) tick();
    rst = 1; tick(); rst = 0;
    wait_ready(n);
    check("reclear_len", n, 32);
    set_rd(0, 5, 1); set_rd(1, 7, 1); set_rd(2, 9, 1);
    #1;
    check("x5_wiped", rdata_o[0 +: DW], 32'd0);
    check("x7_wiped", rdata_o[DW +: DW], 32'd0);
    check("x9_wiped", rdata_o[2*DW +: DW], 32'd0);

    for (int c = 0; c < 3000; c++) begin
      rst    = (c == 1500) || (c == 1512);
      we0    = 1'($urandom_range(0, 1));
      we1    = 1'($urandom_range(0, 1));
      iss_we = ($urandom_range(0, 3) == 0);
      waddr0 = rand_addr();
      waddr1 = rand_addr();
      iss_addr = rand_addr();
      wdata0 = $urandom;
      wdata1 = $urandom;
      for (int k = 0; k < NR; k++) set_rd(k, rand_addr(), ($urandom_range(0, 7) != 0));
      tick();
    end
    rst = 0;
    idle_writes();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
